// File: rtl/fb_mem_server_if.sv
// Framebuffer memory server bus: read-address FIFO pop side, read-data FIFO push
// side, drawing-engine write port and the board SRAM pins.
interface fb_mem_server_if #(
   parameter int ADDR_W = 18
);
   logic              rd_addr_in_ren;
   logic [15:0]       rd_addr_in_rd;
   logic              rd_addr_in_empty;
   logic              rd_data_out_wen;
   logic [15:0]       rd_data_out_wd;
   logic              rd_data_out_full;
   // Write port: requester holds valid and payload until it sees the one-cycle
   // ready pulse; the word is accepted at that pulse and valid may drop after it.
   logic              wr_req_valid;
   logic [15:0]       wr_req_addr;
   logic [15:0]       wr_req_data;
   logic              wr_req_ready;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_out;
   logic              sram_dq_oe;
   logic [15:0]       sram_dq_in;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;

   modport slave (
      input  rd_addr_in_rd, rd_addr_in_empty, rd_data_out_full,
      input  wr_req_valid, wr_req_addr, wr_req_data, sram_dq_in,
      output rd_addr_in_ren, rd_data_out_wen, rd_data_out_wd, wr_req_ready,
      output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
   );

   modport master (
      output rd_addr_in_rd, rd_addr_in_empty, rd_data_out_full,
      output wr_req_valid, wr_req_addr, wr_req_data, sram_dq_in,
      input  rd_addr_in_ren, rd_data_out_wen, rd_data_out_wd, wr_req_ready,
      input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
   );
endinterface

// File: rtl/fb_mem_server.sv
// Framebuffer memory responder: serves renderer reads from the address/data FIFOs
// and drawing-engine writes against an async SRAM, one access at a time.
module fb_mem_server #(
   parameter int ADDR_W       = 18,
   parameter int RD_WAIT      = 2,
   parameter int WR_WAIT      = 2,
   parameter int MAX_RD_BURST = 8
) (
   input  logic           clk,
   input  logic           rst,
   fb_mem_server_if.slave bus,
   output logic [2:0]     state_dbg
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ACC  = 3'd1,
      RD_PUSH = 3'd2,
      WR_ACC  = 3'd3,
      WR_REC  = 3'd4
   } state_t;

   localparam logic [3:0] RD_LAST   = 4'(RD_WAIT - 1);
   localparam logic [3:0] WR_LAST   = 4'(WR_WAIT - 1);
   localparam logic [7:0] BURST_MAX = 8'(MAX_RD_BURST);

   state_t     state;
   logic [3:0] wait_cnt;
   logic [7:0] burst_cnt;
   logic       rd_ok;
   logic       wr_grant;
   logic       rd_grant;

   // A pending write only loses to reads until the burst limit is reached.
   always_comb begin
      rd_ok    = ~bus.rd_addr_in_empty & ~bus.rd_data_out_full;
      wr_grant = (state == IDLE) & bus.wr_req_valid & (~rd_ok | (burst_cnt == BURST_MAX));
      rd_grant = (state == IDLE) & ~wr_grant & rd_ok;
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         wait_cnt           <= '0;
         burst_cnt          <= '0;
         bus.rd_addr_in_ren <= 1'b0;
         bus.rd_data_out_wen <= 1'b0;
         bus.rd_data_out_wd <= '0;
         bus.wr_req_ready   <= 1'b0;
         bus.sram_addr      <= '0;
         bus.sram_dq_out    <= '0;
         bus.sram_dq_oe     <= 1'b0;
         bus.sram_ce_n      <= 1'b1;
         bus.sram_oe_n      <= 1'b1;
         bus.sram_we_n      <= 1'b1;
      end else begin
         bus.rd_addr_in_ren  <= 1'b0;
         bus.rd_data_out_wen <= 1'b0;
         bus.wr_req_ready    <= 1'b0;

         if (!bus.wr_req_valid || wr_grant)
            burst_cnt <= '0;
         else if (rd_grant && burst_cnt != BURST_MAX)
            burst_cnt <= burst_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (wr_grant) begin
                  bus.sram_addr    <= ADDR_W'(bus.wr_req_addr);
                  bus.sram_dq_out  <= bus.wr_req_data;
                  bus.wr_req_ready <= 1'b1;
                  bus.sram_dq_oe   <= 1'b1;
                  bus.sram_ce_n    <= 1'b0;
                  bus.sram_we_n    <= 1'b0;
                  wait_cnt         <= WR_LAST;
                  state            <= WR_ACC;
               end else if (rd_grant) begin
                  bus.sram_addr      <= ADDR_W'(bus.rd_addr_in_rd);
                  bus.sram_ce_n      <= 1'b0;
                  bus.sram_oe_n      <= 1'b0;
                  bus.rd_addr_in_ren <= 1'b1;
                  wait_cnt           <= RD_LAST;
                  state              <= RD_ACC;
               end
            end
            RD_ACC: begin
               if (wait_cnt == 4'd0) begin
                  bus.rd_data_out_wd <= bus.sram_dq_in;
                  bus.sram_ce_n      <= 1'b1;
                  bus.sram_oe_n      <= 1'b1;
                  state              <= RD_PUSH;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RD_PUSH: begin
               if (!bus.rd_data_out_full) begin
                  bus.rd_data_out_wen <= 1'b1;
                  state               <= IDLE;
               end
            end
            WR_ACC: begin
               if (wait_cnt == 4'd0) begin
                  bus.sram_we_n <= 1'b1;
                  bus.sram_ce_n <= 1'b1;
                  state         <= WR_REC;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            WR_REC: begin
               // Data bus released one cycle after we_n rises, before any read.
               bus.sram_dq_oe <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_mem_server.sv
// Bench for fb_mem_server: word-addressed SRAM and FIFO models around the DUT,
// with a memory-image reference and an expected-read-data queue.
module tb_fb_mem_server;
   localparam int ADDR_W       = 18;
   localparam int RD_WAIT      = 2;
   localparam int WR_WAIT      = 2;
   localparam int MAX_RD_BURST = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] state_dbg;

   fb_mem_server_if #(.ADDR_W(ADDR_W)) bus ();

   fb_mem_server #(
      .ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .MAX_RD_BURST(MAX_RD_BURST)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [15:0] sram_mem [0:65535];
   logic [15:0] ref_mem  [0:65535];
   logic [15:0] addr_q [$];
   logic [31:0] wr_q [$];
   logic [15:0] exp_q [$];
   logic        ev_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_dq_oe = 1'b0;
   logic [15:0] last_wd = 16'h0;
   logic [15:0] ren_h, wen_h, rdy_h, oe_lo_h, we_lo_h, dqoe_h;

   assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[15:0]] : 16'hdead;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive();
      bus.rd_addr_in_empty = (addr_q.size() == 0);
      bus.rd_addr_in_rd    = (addr_q.size() == 0) ? 16'h0 : addr_q[0];
      bus.wr_req_valid     = (wr_q.size() != 0);
      {bus.wr_req_addr, bus.wr_req_data} = (wr_q.size() != 0) ? wr_q[0] : 32'h0;
   endtask

   task automatic monitor();
      check("bus_turnaround", 32'(!bus.sram_oe_n && (bus.sram_dq_oe || prev_dq_oe)), 32'h0);
      prev_dq_oe = bus.sram_dq_oe;
      if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
         sram_mem[bus.sram_addr[15:0]] = bus.sram_dq_out;
      if (bus.rd_addr_in_ren) begin
         check("ren_nonempty", 32'(bus.rd_addr_in_empty), 32'h0);
         check("rd_addr", 32'(bus.sram_addr), 32'(bus.rd_addr_in_rd));
         exp_q.push_back(ref_mem[bus.rd_addr_in_rd]);
         ev_q.push_back(1'b0);
      end
      if (bus.wr_req_ready) begin
         check("wr_addr", 32'(bus.sram_addr), 32'(bus.wr_req_addr));
         check("wr_data", 32'(bus.sram_dq_out), 32'(bus.wr_req_data));
         ref_mem[bus.wr_req_addr] = bus.wr_req_data;
         ev_q.push_back(1'b1);
      end
      if (bus.rd_data_out_wen) begin
         last_wd = bus.rd_data_out_wd;
         check("wen_expected", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) check("rd_data", 32'(bus.rd_data_out_wd), 32'(exp_q.pop_front()));
      end
   endtask

   // One clock: observe at the falling edge, then update the FIFO/requester models.
   task automatic step();
      @(negedge clk);
      if (!rst) monitor();
      if (bus.rd_addr_in_ren && addr_q.size() != 0) void'(addr_q.pop_front());
      if (bus.wr_req_ready && wr_q.size() != 0) void'(wr_q.pop_front());
      drive();
   endtask

   task automatic run_window(input int n);
      ren_h = '0; wen_h = '0; rdy_h = '0; oe_lo_h = '0; we_lo_h = '0; dqoe_h = '0;
      for (int i = 0; i < n; i++) begin
         step();
         ren_h[i]   = bus.rd_addr_in_ren;
         wen_h[i]   = bus.rd_data_out_wen;
         rdy_h[i]   = bus.wr_req_ready;
         oe_lo_h[i] = ~bus.sram_oe_n;
         we_lo_h[i] = ~bus.sram_we_n;
         dqoe_h[i]  = bus.sram_dq_oe;
      end
   endtask

   task automatic drain(input int max_cyc);
      logic done;
      done = 1'b0;
      bus.rd_data_out_full = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         step();
         done = (addr_q.size() == 0) && (wr_q.size() == 0) && (exp_q.size() == 0) &&
                bus.sram_ce_n && !bus.sram_dq_oe;
      end
      check("drain_done", 32'(done), 32'h1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_strobes"}, 32'({bus.rd_addr_in_ren, bus.rd_data_out_wen, bus.wr_req_ready,
             bus.sram_dq_oe, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'h07);
      check({tag, "_addr"}, 32'(bus.sram_addr), 32'h0);
      check({tag, "_data"}, {bus.sram_dq_out, bus.rd_data_out_wd}, 32'h0);
   endtask

   initial begin
      logic [15:0] v;
      logic [31:0] seq;
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         sram_mem[i] = v;
         ref_mem[i]  = v;
      end
      bus.rd_data_out_full = 1'b0;
      drive();
      repeat (3) step();
      check_reset_vals("reset");
      rst = 1'b0;

      // Single read of 0x1234
      sram_mem[16'h1234] = 16'hbeef;
      ref_mem[16'h1234]  = 16'hbeef;
      addr_q.push_back(16'h1234);
      drive();
      run_window(8);
      check("rd1_ren", 32'(ren_h), 32'h1);
      check("rd1_oe_low", 32'(oe_lo_h), 32'h3);
      check("rd1_wen", 32'(wen_h), 32'h8);
      check("rd1_wd", 32'(last_wd), 32'hbeef);

      // Back-pressure then release
      bus.rd_data_out_full = 1'b1;
      addr_q.push_back(16'h0100);
      drive();
      run_window(6);
      check("bp_ren", 32'(ren_h), 32'h0);
      check("bp_oe_low", 32'(oe_lo_h), 32'h0);
      bus.rd_data_out_full = 1'b0;
      run_window(8);
      check("bp_rel_ren", 32'(ren_h), 32'h1);
      check("bp_rel_wen", 32'(wen_h), 32'h8);

      // Single write
      sram_mem[16'h0040] = 16'h0;
      ref_mem[16'h0040]  = 16'h0;
      wr_q.push_back({16'h0040, 16'ha5a5});
      drive();
      run_window(8);
      check("wr1_ready", 32'(rdy_h), 32'h1);
      check("wr1_we_low", 32'(we_lo_h), 32'h3);
      check("wr1_dq_oe", 32'(dqoe_h), 32'h7);
      check("wr1_mem", 32'(sram_mem[16'h0040]), 32'ha5a5);

      // Write immediately followed by a read of the same word
      wr_q.push_back({16'h0077, 16'ha5a5});
      drive();
      step();
      addr_q.push_back(16'h0077);
      drive();
      run_window(10);
      check("ta_dq_oe", 32'(dqoe_h), 32'h0003);
      check("ta_oe_low", 32'(oe_lo_h), 32'h0018);
      check("ta_wen", 32'(wen_h), 32'h0040);
      check("ta_wd", 32'(last_wd), 32'ha5a5);

      // Arbitration: six reads queued together with one write
      ev_q.delete();
      for (int k = 0; k < 6; k++) addr_q.push_back(16'h0200 + 16'(k));
      wr_q.push_back({16'h0300, 16'h1357});
      drive();
      drain(200);
      seq = '0;
      for (int i = 0; i < ev_q.size() && i < 32; i++) seq[i] = ev_q[i];
      check("arb_count", 32'(ev_q.size()), 32'd7);
      check("arb_order", seq, 32'h10);

      // Reset during the first read-access cycle
      addr_q.push_back(16'h0400);
      drive();
      step();
      check("rst_ren", 32'(bus.rd_addr_in_ren), 32'h1);
      rst = 1'b1;
      exp_q.delete();
      step();
      check_reset_vals("midrst");
      rst = 1'b0;
      repeat (10) step();
      addr_q.push_back(16'h0401);
      drive();
      run_window(8);
      check("postrst_ren", 32'(ren_h), 32'h1);
      check("postrst_wen", 32'(wen_h), 32'h8);

      // Randomized traffic over a small address range to exercise read-after-write
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 3) == 0) addr_q.push_back(16'($urandom_range(0, 31)));
         if ($urandom_range(0, 9) == 0 && wr_q.size() < 3)
            wr_q.push_back({16'($urandom_range(0, 31)), 16'($urandom)});
         bus.rd_data_out_full = ($urandom_range(0, 3) == 0);
         drive();
         step();
      end
      drain(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
